y86_decode_stage_p: RTL and testbench

Parametrised next-generation Y86 decode stage.
- Contains the architectural register file, with two synchronous write ports driven from writeback.
- Resolves srcA/srcB/dstE/dstM from icode and applies the 5-source forwarding priority.
- Detects load-use and mispredicted-branch hazards.
- Owns the D->E pipeline register, inserting bubbles or holding as required, between fetch and execute.

---
 rtl/y86_decode_stage_p_pkg.sv | 34 +++
 rtl/y86_decode_stage_p_if.sv | 28 ++
 rtl/y86_decode_stage_p_regfile.sv | 48 ++++
 rtl/y86_decode_stage_p.sv | 131 +++++++++++++
 tb/tb_y86_decode_stage_p.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/y86_decode_stage_p_pkg.sv
// Shared Y86 decode definitions: icodes, register ids, status codes and the
// control fields loaded into the E register when a bubble is inserted.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RRSP  = 4'h4;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SADR = 3'd2;
  localparam logic [2:0] SINS = 3'd3;
  localparam logic [2:0] SHLT = 3'd4;

  typedef struct packed {
    logic [3:0] icode;
    logic [3:0] ifun;
    logic [2:0] stat;
  } e_ctl_t;

  localparam e_ctl_t E_BUBBLE = '{icode: INOP, ifun: 4'h0, stat: SAOK};

endpackage

// File: rtl/y86_decode_stage_p_if.sv
// Fetch->decode->execute bus: D_* fields come in from fetch, E_* leave the
// D->E pipeline register, stall_D goes back to fetch.
interface y86_decode_stage_p_if #(
  parameter int DATA_W = 64,
  parameter int REG_W  = 4
);
  logic [3:0]        D_icode, D_ifun;
  logic [REG_W-1:0]  D_rA, D_rB;
  logic [2:0]        D_stat;
  logic [DATA_W-1:0] D_valC, D_valP;
  logic              stall_D;
  logic [3:0]        E_icode, E_ifun;
  logic [2:0]        E_stat;
  logic [DATA_W-1:0] E_valA, E_valB, E_valC;
  logic [REG_W-1:0]  E_dstE, E_dstM, E_srcA, E_srcB;

  modport master (
    output D_icode, D_ifun, D_rA, D_rB, D_stat, D_valC, D_valP,
    input  stall_D, E_icode, E_ifun, E_stat, E_valA, E_valB, E_valC,
           E_dstE, E_dstM, E_srcA, E_srcB
  );

  modport slave (
    input  D_icode, D_ifun, D_rA, D_rB, D_stat, D_valC, D_valP,
    output stall_D, E_icode, E_ifun, E_stat, E_valA, E_valB, E_valC,
           E_dstE, E_dstM, E_srcA, E_srcB
  );
endinterface

// File: rtl/y86_decode_stage_p_regfile.sv
// Architectural register file: two writeback ports (M port wins on collision),
// two operand reads plus a debug read. Out-of-range ids read 0, never write.
module y86_regfile #(
  parameter int DATA_W   = 64,
  parameter int NREG     = 15,
  parameter int REG_W    = 4,
  parameter int RSP_INIT = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_W-1:0]  wr_e_id,
  input  logic [DATA_W-1:0] wr_e_data,
  input  logic [REG_W-1:0]  wr_m_id,
  input  logic [DATA_W-1:0] wr_m_data,
  input  logic [REG_W-1:0]  rd_a_id,
  output logic [DATA_W-1:0] rd_a_data,
  input  logic [REG_W-1:0]  rd_b_id,
  output logic [DATA_W-1:0] rd_b_data,
  input  logic [REG_W-1:0]  dbg_id,
  output logic [DATA_W-1:0] dbg_data
);

  logic [NREG-1:0][DATA_W-1:0] regs;

  always_ff @(posedge clk) begin
    for (int r = 0; r < NREG; r++) begin
      if (!rst_n)
        regs[r] <= (r == 4) ? DATA_W'(RSP_INIT) : '0;
      else if (wr_m_id == REG_W'(r))
        regs[r] <= wr_m_data;
      else if (wr_e_id == REG_W'(r))
        regs[r] <= wr_e_data;
    end
  end

  function automatic logic [DATA_W-1:0] rd(input logic [REG_W-1:0] id);
    logic [DATA_W-1:0] v;
    v = '0;
    for (int r = 0; r < NREG; r++)
      if (id == REG_W'(r)) v = regs[r];
    return v;
  endfunction

  assign rd_a_data = rd(rd_a_id);
  assign rd_b_data = rd(rd_b_id);
  assign dbg_data  = rd(dbg_id);

endmodule

// File: rtl/y86_decode_stage_p.sv
// Y86 decode stage: register file, src/dst decode, 5-source forwarding, hazard
// detection and the D->E register. Y86_DEC_PERF_CNT_EN adds stall/bubble counters.
module y86_decode_stage_p
  import y86_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int NREG     = 15,
  parameter int REG_W    = 4,
  parameter int RSP_INIT = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  y86_decode_stage_p_if.slave dx,
  input  logic [REG_W-1:0]  e_dstE,
  input  logic [DATA_W-1:0] e_valE,
  input  logic              e_Cnd,
  input  logic [REG_W-1:0]  M_dstE,
  input  logic [DATA_W-1:0] M_valE,
  input  logic [REG_W-1:0]  M_dstM,
  input  logic [DATA_W-1:0] m_valM,
  input  logic [REG_W-1:0]  W_dstE,
  input  logic [DATA_W-1:0] W_valE,
  input  logic [REG_W-1:0]  W_dstM,
  input  logic [DATA_W-1:0] W_valM,
  input  logic [REG_W-1:0]  dbg_addr,
  output logic [DATA_W-1:0] dbg_data
`ifdef Y86_DEC_PERF_CNT_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_bubble_cnt
`endif
);

  localparam logic [REG_W-1:0] RNONE_ID = '1;
  localparam logic [REG_W-1:0] RSP_ID   = REG_W'(RRSP);

  logic [REG_W-1:0]  src_a, src_b, dst_e, dst_m;
  logic [DATA_W-1:0] rf_a, rf_b, val_a, val_b;
  logic              load_use, mispredict, bubble;

  y86_regfile #(
    .DATA_W(DATA_W), .NREG(NREG), .REG_W(REG_W), .RSP_INIT(RSP_INIT)
  ) u_rf (
    .clk(clk), .rst_n(rst_n),
    .wr_e_id(W_dstE), .wr_e_data(W_valE),
    .wr_m_id(W_dstM), .wr_m_data(W_valM),
    .rd_a_id(src_a),  .rd_a_data(rf_a),
    .rd_b_id(src_b),  .rd_b_data(rf_b),
    .dbg_id(dbg_addr), .dbg_data(dbg_data)
  );

  always_comb begin
    src_a = RNONE_ID;
    src_b = RNONE_ID;
    dst_e = RNONE_ID;
    dst_m = RNONE_ID;
    case (dx.D_icode)
      IRRMOVQ: begin src_a = dx.D_rA; dst_e = dx.D_rB; end
      IIRMOVQ: dst_e = dx.D_rB;
      IRMMOVQ: begin src_a = dx.D_rA; src_b = dx.D_rB; end
      IMRMOVQ: begin src_b = dx.D_rB; dst_m = dx.D_rA; end
      IOPQ:    begin src_a = dx.D_rA; src_b = dx.D_rB; dst_e = dx.D_rB; end
      ICALL:   begin src_b = RSP_ID; dst_e = RSP_ID; end
      IRET:    begin src_a = RSP_ID; src_b = RSP_ID; dst_e = RSP_ID; end
      IPUSHQ:  begin src_a = dx.D_rA; src_b = RSP_ID; dst_e = RSP_ID; end
      IPOPQ:   begin src_a = RSP_ID; src_b = RSP_ID; dst_e = RSP_ID; dst_m = dx.D_rA; end
      default: ;
    endcase
  end

  // Youngest producer first; W_dstM ahead of W_dstE mirrors the write priority.
  function automatic logic [DATA_W-1:0] fwd(input logic [REG_W-1:0] src,
                                            input logic [DATA_W-1:0] rf);
    if (src == RNONE_ID) return rf;
    if (src == e_dstE)   return e_valE;
    if (src == M_dstM)   return m_valM;
    if (src == M_dstE)   return M_valE;
    if (src == W_dstM)   return W_valM;
    if (src == W_dstE)   return W_valE;
    return rf;
  endfunction

  assign val_a = (dx.D_icode == ICALL || dx.D_icode == IJXX) ? dx.D_valP : fwd(src_a, rf_a);
  assign val_b = fwd(src_b, rf_b);

  assign load_use   = (dx.E_icode == IMRMOVQ || dx.E_icode == IPOPQ) &&
                      (dx.E_dstM != RNONE_ID) &&
                      (dx.E_dstM == src_a || dx.E_dstM == src_b);
  assign mispredict = (dx.E_icode == IJXX) && !e_Cnd;
  assign bubble     = load_use || mispredict;
  assign dx.stall_D = load_use && !mispredict;

  always_ff @(posedge clk) begin
    if (!rst_n || bubble) begin
      dx.E_icode <= E_BUBBLE.icode;
      dx.E_ifun  <= E_BUBBLE.ifun;
      dx.E_stat  <= E_BUBBLE.stat;
      dx.E_valA  <= '0;
      dx.E_valB  <= '0;
      dx.E_valC  <= '0;
      dx.E_dstE  <= RNONE_ID;
      dx.E_dstM  <= RNONE_ID;
      dx.E_srcA  <= RNONE_ID;
      dx.E_srcB  <= RNONE_ID;
    end else begin
      dx.E_icode <= dx.D_icode;
      dx.E_ifun  <= dx.D_ifun;
      dx.E_stat  <= dx.D_stat;
      dx.E_valA  <= val_a;
      dx.E_valB  <= val_b;
      dx.E_valC  <= dx.D_valC;
      dx.E_dstE  <= dst_e;
      dx.E_dstM  <= dst_m;
      dx.E_srcA  <= src_a;
      dx.E_srcB  <= src_b;
    end
  end

`ifdef Y86_DEC_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else begin
      if (dx.stall_D && perf_stall_cnt != '1) perf_stall_cnt  <= perf_stall_cnt + 32'd1;
      if (bubble && perf_bubble_cnt != '1)    perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_y86_decode_stage_p.sv
// Directed bench for y86_decode_stage_p: reset, register reads, forwarding,
// load-use, mispredict, writeback collisions and reset during a stall.
module tb_y86_decode_stage_p;
  import y86_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM, dbg_addr;
  logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM, dbg_data;
  logic        e_Cnd;
  int          checks = 0;
  int          errors = 0;
`ifdef Y86_DEC_PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_bubble_cnt;
`endif

  y86_decode_stage_p_if #(.DATA_W(64), .REG_W(4)) dx ();

  y86_decode_stage_p #(.DATA_W(64), .NREG(15), .REG_W(4), .RSP_INIT(256)) dut (
    .clk(clk), .rst_n(rst_n), .dx(dx),
    .e_dstE(e_dstE), .e_valE(e_valE), .e_Cnd(e_Cnd),
    .M_dstE(M_dstE), .M_valE(M_valE), .M_dstM(M_dstM), .m_valM(m_valM),
    .W_dstE(W_dstE), .W_valE(W_valE), .W_dstM(W_dstM), .W_valM(W_valM),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
`ifdef Y86_DEC_PERF_CNT_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_bubble_cnt(perf_bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_fwd();
    e_dstE = 4'hF; e_valE = '0; e_Cnd = 1'b1;
    M_dstE = 4'hF; M_valE = '0; M_dstM = 4'hF; m_valM = '0;
    W_dstE = 4'hF; W_valE = '0; W_dstM = 4'hF; W_valM = '0;
  endtask

  task automatic set_d(input logic [3:0] icode, input logic [3:0] ifun,
                       input logic [3:0] ra, input logic [3:0] rb,
                       input logic [63:0] valc, input logic [63:0] valp);
    dx.D_icode = icode; dx.D_ifun = ifun; dx.D_rA = ra; dx.D_rB = rb;
    dx.D_stat = SAOK; dx.D_valC = valc; dx.D_valP = valp;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_fwd();
    set_d(INOP, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0);
    dbg_addr = 4'h4;
    tick(); tick();
    rst_n = 1'b1;
    #1;
    checks++; if (dbg_data !== 64'd256) begin errors++; $display("FAIL reset_rsp got %h exp %h", dbg_data, 64'd256); end
    dbg_addr = 4'h0; #1;
    checks++; if (dbg_data !== 64'd0) begin errors++; $display("FAIL reset_r0 got %h exp 0", dbg_data); end
    dbg_addr = 4'hF; #1;
    checks++; if (dbg_data !== 64'd0) begin errors++; $display("FAIL read_rnone got %h exp 0", dbg_data); end
    checks++; if (dx.E_icode !== 4'h1) begin errors++; $display("FAIL reset_E_icode got %h exp 1", dx.E_icode); end
    checks++; if (dx.E_dstE !== 4'hF) begin errors++; $display("FAIL reset_E_dstE got %h exp f", dx.E_dstE); end
    checks++; if (dx.E_stat !== 3'd1 || dx.E_valA !== 64'd0) begin errors++; $display("FAIL reset_E_stat_valA got %h/%h exp 1/0", dx.E_stat, dx.E_valA); end
    checks++; if (dx.stall_D !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", dx.stall_D); end
`ifdef Y86_DEC_PERF_CNT_EN
    checks++; if (perf_stall_cnt !== 32'd0 || perf_bubble_cnt !== 32'd0) begin errors++; $display("FAIL reset_perf got %0d/%0d exp 0/0", perf_stall_cnt, perf_bubble_cnt); end
`endif
  endtask

  task automatic test_rf_read();
    clear_fwd();
    set_d(IIRMOVQ, 4'h0, 4'hF, 4'h2, 64'h55, 64'h0A);
    W_dstE = 4'h2; W_valE = 64'h55;
    tick();
    checks++; if (dx.E_icode !== IIRMOVQ || dx.E_dstE !== 4'h2 || dx.E_valC !== 64'h55 || dx.E_srcA !== 4'hF)
      begin errors++; $display("FAIL irmovq_E got icode %h dstE %h valC %h srcA %h exp 3/2/55/f", dx.E_icode, dx.E_dstE, dx.E_valC, dx.E_srcA); end
    W_dstE = 4'hF;
    set_d(IRRMOVQ, 4'h0, 4'h2, 4'h3, 64'h0, 64'h0);
    tick();
    checks++; if (dx.E_valA !== 64'h55 || dx.E_dstE !== 4'h3) begin errors++; $display("FAIL rf_read got valA %h dstE %h exp 55/3", dx.E_valA, dx.E_dstE); end
    set_d(IRRMOVQ, 4'h0, 4'h6, 4'h7, 64'h0, 64'h0);
    W_dstE = 4'h6; W_valE = 64'h66;
    tick();
    checks++; if (dx.E_valA !== 64'h66) begin errors++; $display("FAIL w_fwd got %h exp 66", dx.E_valA); end
    set_d(IRRMOVQ, 4'h0, 4'h8, 4'h9, 64'h0, 64'h0);
    W_dstE = 4'h8; W_valE = 64'h11; W_dstM = 4'h8; W_valM = 64'h88;
    tick();
    checks++; if (dx.E_valA !== 64'h88) begin errors++; $display("FAIL w_dstM_prio got %h exp 88", dx.E_valA); end
    clear_fwd();
    dbg_addr = 4'h8; #1;
    checks++; if (dbg_data !== 64'h88) begin errors++; $display("FAIL w_collide_r8 got %h exp 88", dbg_data); end
  endtask

  task automatic test_fwd_priority();
    clear_fwd();
    e_dstE = 4'h3; e_valE = 64'd7; M_dstE = 4'h3; M_valE = 64'd9;
    set_d(IOPQ, 4'h0, 4'h3, 4'h9, 64'h0, 64'h0);
    tick();
    checks++; if (dx.E_valA !== 64'd7 || dx.E_valB !== 64'd0) begin errors++; $display("FAIL e_prio got %h/%h exp 7/0", dx.E_valA, dx.E_valB); end
    e_dstE = 4'hF; M_dstM = 4'h3; m_valM = 64'h30;
    set_d(IOPQ, 4'h0, 4'h3, 4'h3, 64'h0, 64'h0);
    tick();
    checks++; if (dx.E_valA !== 64'h30 || dx.E_valB !== 64'h30) begin errors++; $display("FAIL mM_prio got %h/%h exp 30/30", dx.E_valA, dx.E_valB); end
    M_dstM = 4'hF;
    set_d(IOPQ, 4'h0, 4'hA, 4'h3, 64'h0, 64'h0);
    tick();
    checks++; if (dx.E_valB !== 64'd9 || dx.E_valA !== 64'd0) begin errors++; $display("FAIL ME_valB got %h/%h exp 0/9", dx.E_valA, dx.E_valB); end
    clear_fwd();
    e_dstE = 4'hF; e_valE = 64'hDEAD; W_valE = 64'hBEEF;
    set_d(IIRMOVQ, 4'h0, 4'hF, 4'h5, 64'h0, 64'h0);
    tick();
    checks++; if (dx.E_valA !== 64'd0) begin errors++; $display("FAIL rnone_nomatch got %h exp 0", dx.E_valA); end
    clear_fwd();
    set_d(IPUSHQ, 4'h0, 4'h2, 4'hF, 64'h0, 64'h0);
    tick();
    checks++; if (dx.E_valA !== 64'h55 || dx.E_valB !== 64'd256 || dx.E_dstE !== 4'h4) begin errors++; $display("FAIL pushq got %h/%h/%h exp 55/100/4", dx.E_valA, dx.E_valB, dx.E_dstE); end
    set_d(ICALL, 4'h0, 4'hF, 4'hF, 64'h100, 64'h1234);
    tick();
    checks++; if (dx.E_valA !== 64'h1234 || dx.E_valB !== 64'd256 || dx.E_srcB !== 4'h4) begin errors++; $display("FAIL call_valP got %h/%h/%h exp 1234/100/4", dx.E_valA, dx.E_valB, dx.E_srcB); end
  endtask

  task automatic test_load_use();
    clear_fwd();
    set_d(IMRMOVQ, 4'h0, 4'h1, 4'h2, 64'h0, 64'h0);
    tick();
    checks++; if (dx.E_icode !== IMRMOVQ || dx.E_dstM !== 4'h1) begin errors++; $display("FAIL mrmovq_E got %h/%h exp 5/1", dx.E_icode, dx.E_dstM); end
    set_d(IOPQ, 4'h0, 4'h1, 4'h3, 64'h0, 64'h0);
    #1;
    checks++; if (dx.stall_D !== 1'b1) begin errors++; $display("FAIL lu_stall got %b exp 1", dx.stall_D); end
    tick();
    checks++; if (dx.E_icode !== INOP || dx.E_dstE !== 4'hF) begin errors++; $display("FAIL lu_bubble got %h/%h exp 1/f", dx.E_icode, dx.E_dstE); end
    checks++; if (dx.stall_D !== 1'b0) begin errors++; $display("FAIL lu_release got %b exp 0", dx.stall_D); end
    M_dstM = 4'h1; m_valM = 64'h77;
    tick();
    checks++; if (dx.E_icode !== IOPQ || dx.E_valA !== 64'h77) begin errors++; $display("FAIL lu_fwd got %h/%h exp 6/77", dx.E_icode, dx.E_valA); end
  endtask

  task automatic test_mispredict();
    clear_fwd();
    set_d(IJXX, 4'h1, 4'hF, 4'hF, 64'h200, 64'h30);
    tick();
    checks++; if (dx.E_icode !== IJXX || dx.E_valA !== 64'h30) begin errors++; $display("FAIL jxx_E got %h/%h exp 7/30", dx.E_icode, dx.E_valA); end
    e_Cnd = 1'b0;
    set_d(IOPQ, 4'h0, 4'h1, 4'h2, 64'h0, 64'h0);
    #1;
    checks++; if (dx.stall_D !== 1'b0) begin errors++; $display("FAIL mp_stall got %b exp 0", dx.stall_D); end
    tick();
    checks++; if (dx.E_icode !== INOP || dx.E_srcA !== 4'hF) begin errors++; $display("FAIL mp_bubble got %h/%h exp 1/f", dx.E_icode, dx.E_srcA); end
    set_d(IJXX, 4'h1, 4'hF, 4'hF, 64'h200, 64'h30);
    tick();
    e_Cnd = 1'b1;
    set_d(IOPQ, 4'h0, 4'h1, 4'h2, 64'h0, 64'h0);
    tick();
    checks++; if (dx.E_icode !== IOPQ) begin errors++; $display("FAIL taken_pass got %h exp 6", dx.E_icode); end
  endtask

  task automatic test_reg_write();
    clear_fwd();
    set_d(INOP, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0);
    W_dstE = 4'h5; W_valE = 64'd1; W_dstM = 4'h5; W_valM = 64'd2;
    tick();
    clear_fwd();
    dbg_addr = 4'h5; #1;
    checks++; if (dbg_data !== 64'd2) begin errors++; $display("FAIL same_reg_write got %h exp 2", dbg_data); end
    W_dstE = 4'hE; W_valE = 64'hEE; W_dstM = 4'hF; W_valM = 64'hFF;
    tick();
    clear_fwd();
    dbg_addr = 4'hE; #1;
    checks++; if (dbg_data !== 64'hEE) begin errors++; $display("FAIL r14_write got %h exp ee", dbg_data); end
    dbg_addr = 4'hF; #1;
    checks++; if (dbg_data !== 64'h0) begin errors++; $display("FAIL rnone_write got %h exp 0", dbg_data); end
  endtask

  task automatic test_reset_mid_stall();
    clear_fwd();
    set_d(IMRMOVQ, 4'h0, 4'h1, 4'h2, 64'h0, 64'h0);
    tick();
    set_d(IOPQ, 4'h0, 4'h1, 4'h3, 64'h0, 64'h0);
    #1;
    checks++; if (dx.stall_D !== 1'b1) begin errors++; $display("FAIL pre_rst_stall got %b exp 1", dx.stall_D); end
    rst_n = 1'b0; W_dstE = 4'h5; W_valE = 64'h99;
    tick();
    rst_n = 1'b1;
    clear_fwd();
    dbg_addr = 4'h5; #1;
    checks++; if (dx.E_icode !== INOP || dx.stall_D !== 1'b0) begin errors++; $display("FAIL rst_stall got %h/%b exp 1/0", dx.E_icode, dx.stall_D); end
    checks++; if (dbg_data !== 64'h0) begin errors++; $display("FAIL rst_over_write got %h exp 0", dbg_data); end
  endtask

`ifdef Y86_DEC_PERF_CNT_EN
  task automatic test_perf();
    rst_n = 1'b0;
    clear_fwd();
    set_d(INOP, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_d(IMRMOVQ, 4'h0, 4'h1, 4'h2, 64'h0, 64'h0);
      tick();
      set_d(IOPQ, 4'h0, 4'h1, 4'h3, 64'h0, 64'h0);
      tick();
    end
    checks++; if (perf_stall_cnt !== 32'd3) begin errors++; $display("FAIL perf_stall got %0d exp 3", perf_stall_cnt); end
    checks++; if (perf_bubble_cnt !== 32'd3) begin errors++; $display("FAIL perf_bubble got %0d exp 3", perf_bubble_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_rf_read();
    test_fwd_priority();
    test_load_use();
    test_mispredict();
    test_reg_write();
    test_reset_mid_stall();
`ifdef Y86_DEC_PERF_CNT_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
